candy_regfile_mp: RTL and testbench
===================================

# candy_regfile_mp

Parametrised multi-port general-purpose register file with an integrated busy scoreboard, replacing the fixed 2-read/1-write file in the decode stage. Provides NRD registered read ports with same-cycle write bypass, NWR write ports with fixed priority, and per-register busy bits so decode can detect RAW hazards against in-flight producers. Sits between the decode stage (read, issue) and the writeback stage (write).

## Interface

- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, ≥ 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 reads zero, ignores writes and is never busy.
- AW, derived, $clog2(NUM_REGS).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- we  input  NWR  write enable per write port.
- waddr  input  NWR*AW  write addresses, port k at [k*AW +: AW].
- wdata  input  NWR*DATA_W  write data, port k at [k*DATA_W +: DATA_W].
- re  input  NRD  read enable per read port.
- raddr  input  NRD*AW  read addresses, packed as waddr.
- rdata  output  NRD*DATA_W  registered read data.
- rbusy  output  NRD  registered busy flag of the addressed register.
- set_busy  input  1  issue of a producer: mark set_addr busy.
- set_addr  input  AW  destination register of the issued producer.
- flush  input  1  synchronous clear of all busy bits.

## Operation

- Write: for each port k with we[k] set, regs[waddr_k] <= wdata_k. With several ports on the same address, the highest-index port wins. Writes to r0 are dropped when ZERO_REG=1.
- Read: each port j independently samples on the clock edge:
  - re[j]=0 gives rdata_j=0 and rbusy_j=0.
  - raddr_j=0 with ZERO_REG=1 gives rdata_j=0 and rbusy_j=0.
  - If any enabled write port targets raddr_j this cycle, rdata_j takes the winning port's wdata (bypass).
  - Otherwise rdata_j takes regs[raddr_j].
- Busy scoreboard, one bit per register:
  - Any write to register r clears busy[r].
  - set_busy sets busy[set_addr].
  - Set and clear on the same register in the same cycle: set wins, because the new producer supersedes.
  - flush clears all bits and has priority over set_busy.
  - set_busy to r0 is ignored when ZERO_REG=1.
- rbusy_j reflects next-state busy, so a write that clears the bit in the same cycle reads as not busy, consistent with the bypassed data.

## Timing

- Read latency is one cycle: address and enable at edge n give rdata/rbusy valid after edge n.
- Write-to-read latency is zero cycles via the bypass. A write at edge n is also visible to reads issued at edge n+1 and later through the array.
- Reset, while rst is low, asynchronously forces:
  - rdata=0, rbusy=0
  - all busy bits=0
  - all registers=0
- Reset release is synchronous to clk. Writes and set_busy presented in the cycle reset deasserts are taken at the first rising edge with rst high.
- Reset asserted mid-operation discards any in-flight write of that cycle.
- No back-pressure; all ports accept every cycle.

## Structure

- defines.v gains:
  - RegBus, RegAddrBus and RegNum derived from DATA_W/AW/NUM_REGS defaults.
  - WriteEnable/ReadEnable.
  - ZeroWord.
- candy_regfile_fwd is a sub-module, instantiated once per read port. It is purely combinational and, given all write ports plus the array word, selects the highest-priority matching write or the array value, and computes the next-state busy.
- The top level holds:
  - the array and the busy vector;
  - write-priority resolution, implemented as a generate loop from port 0 upward so the last port assigns.
  - output registers.

## Test plan

- Reset, then write 0xDEADBEEF to r5 on port 0, then read r5 on port 1 next cycle: rdata_1=0xDEADBEEF one cycle after the read.
- Same-cycle bypass: write r7=0x11 on port 0 while port 0 reads r7: rdata_0=0x11 after that edge. In the same cycle, port 1 reads r8 (never written) and gets 0.
- Write conflict: port 0 writes r3=0xAAAA and port 1 writes r3=0x5555 in the same cycle. A later read of r3 gives 0x5555.
- Scoreboard:
  - set_busy r9, then reading r9 shows rbusy=1.
  - A write to r9 combined with a read of r9 gives rbusy=0 with bypassed data.
  - set_busy r9 plus a write to r9 in the same cycle leaves rbusy=1 on the next read.
- r0 and flush:
  - Write 0xFF to r0 and set_busy r0: a read of r0 gives 0 and rbusy=0.
  - With r2 and r4 busy, flush in the same cycle as set_busy r6 leaves all three not busy.
- Async reset mid-stream: assert rst low between edges while r5 holds data. rdata/rbusy go to 0 immediately, and after release a read of r5 returns 0.

Source files
------------

// File: rtl/candy_regfile_mp_pkg.sv
// Shared defaults and type aliases for the candy multi-port register file.
// Holds the bus types, enable levels and zero word used by decode and writeback.
package candy_regfile_mp_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int REG_NUM      = NUM_REGS_DEF;

  typedef logic [DATA_W_DEF-1:0] reg_bus_t;
  typedef logic [AW_DEF-1:0]     reg_addr_bus_t;

  localparam logic     WRITE_ENABLE = 1'b1;
  localparam logic     READ_ENABLE  = 1'b1;
  localparam reg_bus_t ZERO_WORD    = '0;

endpackage

// File: rtl/candy_regfile_fwd.sv
// Per-read-port forwarding: picks the highest-priority matching write or the
// array word, and computes the next-state busy bit of the addressed register.
module candy_regfile_fwd
  import candy_regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AW       = AW_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]     arr_word,
  input  logic                  busy_cur,
  input  logic                  set_busy,
  input  logic [AW-1:0]         set_addr,
  input  logic                  flush,
  output logic [DATA_W-1:0]     rdata_nxt,
  output logic                  rbusy_nxt
);

  logic hit;

  // NOTE: combinational logic uses blocking '=' with a default for every
  // output first, so the later-port override is ordered and no latch appears.
  always_comb begin
    hit       = 1'b0;
    rdata_nxt = arr_word;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] == WRITE_ENABLE && waddr[k*AW +: AW] == raddr) begin
        hit       = 1'b1;
        rdata_nxt = wdata[k*DATA_W +: DATA_W];
      end
    end

    // A new producer supersedes the retiring write; flush overrides both.
    if (flush)                                rbusy_nxt = 1'b0;
    else if (set_busy && set_addr == raddr)   rbusy_nxt = 1'b1;
    else if (hit)                             rbusy_nxt = 1'b0;
    else                                      rbusy_nxt = busy_cur;

    if (re != READ_ENABLE || (ZERO_REG != 0 && raddr == '0)) begin
      rdata_nxt = '0;
      rbusy_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/candy_regfile_mp.sv
// Multi-port register file with write bypass and a RAW busy scoreboard,
// between decode (read/issue) and writeback (write).
module candy_regfile_mp
  import candy_regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  set_busy,
  input  logic [AW-1:0]         set_addr,
  input  logic                  flush
);

  logic [DATA_W-1:0]     regs    [NUM_REGS];
  logic [DATA_W-1:0]     wr_word [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [NRD*DATA_W-1:0] rdata_nxt;
  logic [NRD-1:0]        rbusy_nxt;

  // Ports are walked from 0 upward so the highest-index port lands last.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_word[r] = regs[r];
    for (int k = 0; k < NWR; k++) begin
      if (we[k] == WRITE_ENABLE) begin
        wr_hit[waddr[k*AW +: AW]]  = 1'b1;
        wr_word[waddr[k*AW +: AW]] = wdata[k*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0]  = 1'b0;
      wr_word[0] = '0;
    end
  end

  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (set_busy && !(ZERO_REG != 0 && set_addr == '0)) busy_nxt[set_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end

  // NOTE: the array is deliberately reset: after reset every register must
  // read as zero, so this storage cannot map to a reset-less RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= wr_word[r];
      busy <= busy_nxt;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    candy_regfile_fwd #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_fwd (
      .re        (re[j]),
      .raddr     (raddr[j*AW +: AW]),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .arr_word  (regs[raddr[j*AW +: AW]]),
      .busy_cur  (busy[raddr[j*AW +: AW]]),
      .set_busy  (set_busy),
      .set_addr  (set_addr),
      .flush     (flush),
      .rdata_nxt (rdata_nxt[j*DATA_W +: DATA_W]),
      .rbusy_nxt (rbusy_nxt[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      rbusy <= '0;
    end else begin
      rdata <= rdata_nxt;
      rbusy <= rbusy_nxt;
    end
  end

endmodule

// File: tb/tb_candy_regfile_mp.sv
// Self-checking bench for candy_regfile_mp: directed scenarios plus random
// traffic against an architectural next-state model.
module tb_candy_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [1:0]    we;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    re;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]    rbusy;
  logic          set_busy;
  logic [AW-1:0] set_addr;
  logic          flush;

  int n_total  = 0;
  int n_passed = 0;

  logic [DW-1:0] mdl_regs [NR];
  logic          mdl_busy [NR];
  logic [DW-1:0] exp_rdata [2];
  logic          exp_rbusy [2];

  candy_regfile_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    set_busy = 1'b0; set_addr = '0; flush = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1; waddr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a);
    re[j] = 1'b1; raddr[j*AW +: AW] = a;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mdl_regs[r] = '0;
      mdl_busy[r] = 1'b0;
    end
  endtask

  // Reads return the architectural state after this edge's updates.
  task automatic tick();
    logic [DW-1:0] nr [NR];
    logic          nb [NR];
    int a;
    nr = mdl_regs;
    nb = mdl_busy;
    for (int k = 0; k < 2; k++) begin
      a = int'(waddr[k*AW +: AW]);
      if (we[k] && a != 0) begin
        nr[a] = wdata[k*DW +: DW];
        nb[a] = 1'b0;
      end
    end
    if (set_busy && set_addr != 0) nb[set_addr] = 1'b1;
    if (flush) for (int r = 0; r < NR; r++) nb[r] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      a = int'(raddr[j*AW +: AW]);
      exp_rdata[j] = re[j] ? nr[a] : '0;
      exp_rbusy[j] = re[j] ? nb[a] : 1'b0;
    end
    @(posedge clk);
    #1;
    mdl_regs = nr;
    mdl_busy = nb;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (rdata !== '0 || rbusy !== '0)
      $display("FAIL reset_outputs: rdata=%h rbusy=%b, want 0/0", rdata, rbusy);
    else n_passed++;
    model_reset();
    wr(0, 5'd5, 32'hBAD0_BAD0);
    rd(0, 5'd5);
    set_busy = 1'b1; set_addr = 5'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (rdata !== '0 || rbusy !== '0)
      $display("FAIL reset_held: rdata=%h rbusy=%b, want 0/0", rdata, rbusy);
    else n_passed++;
    #2 rst = 1'b1;
    clear_inputs();
    rd(0, 5'd5);
    tick();
    n_total++;
    if (rdata[DW-1:0] !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL reset_write_dropped: r5=%h busy=%b, want 0/0", rdata[DW-1:0], rbusy[0]);
    else n_passed++;
  endtask

  task automatic test_write_read();
    clear_inputs();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    clear_inputs();
    rd(1, 5'd5);
    tick();
    n_total++;
    if (rdata[DW +: DW] !== 32'hDEAD_BEEF)
      $display("FAIL write_read: rdata1=%h, want deadbeef", rdata[DW +: DW]);
    else n_passed++;
  endtask

  task automatic test_bypass();
    clear_inputs();
    wr(0, 5'd7, 32'h11);
    rd(0, 5'd7);
    rd(1, 5'd8);
    tick();
    n_total++;
    if (rdata[0 +: DW] !== 32'h11)
      $display("FAIL bypass: rdata0=%h, want 11", rdata[0 +: DW]);
    else n_passed++;
    n_total++;
    if (rdata[DW +: DW] !== 32'h0 || rbusy !== 2'b00)
      $display("FAIL bypass_other: rdata1=%h rbusy=%b, want 0/00", rdata[DW +: DW], rbusy);
    else n_passed++;
  endtask

  task automatic test_conflict();
    clear_inputs();
    wr(0, 5'd3, 32'hAAAA);
    wr(1, 5'd3, 32'h5555);
    tick();
    clear_inputs();
    rd(0, 5'd3);
    tick();
    n_total++;
    if (rdata[0 +: DW] !== 32'h5555)
      $display("FAIL write_conflict: r3=%h, want 5555", rdata[0 +: DW]);
    else n_passed++;
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    set_busy = 1'b1; set_addr = 5'd9;
    tick();
    clear_inputs();
    rd(0, 5'd9);
    tick();
    n_total++;
    if (rbusy[0] !== 1'b1)
      $display("FAIL busy_set: rbusy0=%b, want 1", rbusy[0]);
    else n_passed++;
    clear_inputs();
    wr(0, 5'd9, 32'h99);
    rd(0, 5'd9);
    tick();
    n_total++;
    if (rbusy[0] !== 1'b0 || rdata[0 +: DW] !== 32'h99)
      $display("FAIL busy_clear_bypass: rbusy0=%b rdata0=%h, want 0/99", rbusy[0], rdata[0 +: DW]);
    else n_passed++;
    clear_inputs();
    set_busy = 1'b1; set_addr = 5'd9;
    wr(1, 5'd9, 32'h77);
    tick();
    clear_inputs();
    rd(0, 5'd9);
    tick();
    n_total++;
    if (rbusy[0] !== 1'b1 || rdata[0 +: DW] !== 32'h77)
      $display("FAIL busy_set_wins: rbusy0=%b rdata0=%h, want 1/77", rbusy[0], rdata[0 +: DW]);
    else n_passed++;
  endtask

  task automatic test_zero_flush();
    clear_inputs();
    wr(0, 5'd0, 32'hFF);
    set_busy = 1'b1; set_addr = 5'd0;
    tick();
    clear_inputs();
    rd(0, 5'd0);
    tick();
    n_total++;
    if (rdata[0 +: DW] !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL zero_reg: rdata0=%h rbusy0=%b, want 0/0", rdata[0 +: DW], rbusy[0]);
    else n_passed++;
    clear_inputs();
    set_busy = 1'b1; set_addr = 5'd2;
    tick();
    clear_inputs();
    set_busy = 1'b1; set_addr = 5'd4;
    rd(0, 5'd2);
    rd(1, 5'd4);
    tick();
    n_total++;
    if (rbusy !== 2'b11)
      $display("FAIL busy_pre_flush: rbusy=%b, want 11", rbusy);
    else n_passed++;
    clear_inputs();
    flush = 1'b1;
    set_busy = 1'b1; set_addr = 5'd6;
    tick();
    clear_inputs();
    rd(0, 5'd2);
    rd(1, 5'd4);
    tick();
    n_total++;
    if (rbusy !== 2'b00)
      $display("FAIL flush_r2_r4: rbusy=%b, want 00", rbusy);
    else n_passed++;
    clear_inputs();
    rd(0, 5'd6);
    tick();
    n_total++;
    if (rbusy[0] !== 1'b0)
      $display("FAIL flush_over_set: rbusy0=%b, want 0", rbusy[0]);
    else n_passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1) wr(k, 5'($urandom_range(0, 7)), $urandom);
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 3) != 0) rd(j, 5'($urandom_range(0, 7)));
      set_busy = ($urandom_range(0, 2) == 0);
      set_addr = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      tick();
      for (int j = 0; j < 2; j++) begin
        n_total++;
        if (rdata[j*DW +: DW] !== exp_rdata[j])
          $display("FAIL rand_rdata%0d cyc %0d: got %h, want %h", j, c, rdata[j*DW +: DW], exp_rdata[j]);
        else n_passed++;
        n_total++;
        if (rbusy[j] !== exp_rbusy[j])
          $display("FAIL rand_rbusy%0d cyc %0d: got %b, want %b", j, c, rbusy[j], exp_rbusy[j]);
        else n_passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    wr(0, 5'd5, 32'h1234);
    tick();
    clear_inputs();
    rd(0, 5'd5);
    set_busy = 1'b1; set_addr = 5'd5;
    tick();
    n_total++;
    if (rdata[0 +: DW] !== 32'h1234 || rbusy[0] !== 1'b1)
      $display("FAIL pre_async_reset: rdata0=%h rbusy0=%b, want 1234/1", rdata[0 +: DW], rbusy[0]);
    else n_passed++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (rdata !== '0 || rbusy !== '0)
      $display("FAIL async_reset: rdata=%h rbusy=%b, want 0/0", rdata, rbusy);
    else n_passed++;
    model_reset();
    #2 rst = 1'b1;
    clear_inputs();
    rd(0, 5'd5);
    tick();
    n_total++;
    if (rdata[0 +: DW] !== 32'h0 || rbusy[0] !== 1'b0)
      $display("FAIL post_reset_r5: rdata0=%h rbusy0=%b, want 0/0", rdata[0 +: DW], rbusy[0]);
    else n_passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
